// File: rtl/mips_pkg.sv
// mips_pkg: MIPS-I mnemonic enum, opcode/funct/register constants and word packers shared with the decoder
package mips_pkg;

   typedef enum logic [5:0] {
      OP_NOP   = 6'd0,
      OP_SLL   = 6'd1,
      OP_SRL   = 6'd2,
      OP_SRA   = 6'd3,
      OP_JR    = 6'd4,
      OP_JALR  = 6'd5,
      OP_ADD   = 6'd6,
      OP_ADDU  = 6'd7,
      OP_SUB   = 6'd8,
      OP_SUBU  = 6'd9,
      OP_AND   = 6'd10,
      OP_OR    = 6'd11,
      OP_SLT   = 6'd12,
      OP_ADDI  = 6'd13,
      OP_ADDIU = 6'd14,
      OP_ANDI  = 6'd15,
      OP_ORI   = 6'd16,
      OP_LUI   = 6'd17,
      OP_LW    = 6'd18,
      OP_SW    = 6'd19,
      OP_BEQ   = 6'd20,
      OP_BNE   = 6'd21,
      OP_J     = 6'd22,
      OP_JAL   = 6'd23
   } op_e;

   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] OPC_J       = 6'h02;
   localparam logic [5:0] OPC_JAL     = 6'h03;
   localparam logic [5:0] OPC_BEQ     = 6'h04;
   localparam logic [5:0] OPC_BNE     = 6'h05;
   localparam logic [5:0] OPC_ADDI    = 6'h08;
   localparam logic [5:0] OPC_ADDIU   = 6'h09;
   localparam logic [5:0] OPC_ANDI    = 6'h0C;
   localparam logic [5:0] OPC_ORI     = 6'h0D;
   localparam logic [5:0] OPC_LUI     = 6'h0F;
   localparam logic [5:0] OPC_LW      = 6'h23;
   localparam logic [5:0] OPC_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] T0 = 5'd8;
   localparam logic [4:0] T1 = 5'd9;
   localparam logic [4:0] T2 = 5'd10;
   localparam logic [4:0] T5 = 5'd13;
   localparam logic [4:0] RA = 5'd31;

   function automatic logic [31:0] r_word(input logic [4:0] rs, rt, rd, shamt, input logic [5:0] funct);
      return {OPC_SPECIAL, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
      return {opc, target};
   endfunction

endpackage

// File: rtl/mips_field_encoder.sv
// mips_field_encoder: packs decoded fields into a MIPS-I word, zeroing fields the form does not use
module mips_field_encoder
   import mips_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] inst,
   output logic        illegal
);

   always_comb begin
      inst    = '0;
      illegal = 1'b0;
      case (op)
         OP_NOP:   inst = '0;
         OP_SLL:   inst = r_word(REG_ZERO, rt, rd, shamt, FN_SLL);
         OP_SRL:   inst = r_word(REG_ZERO, rt, rd, shamt, FN_SRL);
         OP_SRA:   inst = r_word(REG_ZERO, rt, rd, shamt, FN_SRA);
         OP_JR:    inst = r_word(rs, REG_ZERO, REG_ZERO, 5'd0, FN_JR);
         OP_JALR:  inst = r_word(rs, REG_ZERO, rd, 5'd0, FN_JALR);
         OP_ADD:   inst = r_word(rs, rt, rd, 5'd0, FN_ADD);
         OP_ADDU:  inst = r_word(rs, rt, rd, 5'd0, FN_ADDU);
         OP_SUB:   inst = r_word(rs, rt, rd, 5'd0, FN_SUB);
         OP_SUBU:  inst = r_word(rs, rt, rd, 5'd0, FN_SUBU);
         OP_AND:   inst = r_word(rs, rt, rd, 5'd0, FN_AND);
         OP_OR:    inst = r_word(rs, rt, rd, 5'd0, FN_OR);
         OP_SLT:   inst = r_word(rs, rt, rd, 5'd0, FN_SLT);
         OP_ADDI:  inst = i_word(OPC_ADDI, rs, rt, imm);
         OP_ADDIU: inst = i_word(OPC_ADDIU, rs, rt, imm);
         OP_ANDI:  inst = i_word(OPC_ANDI, rs, rt, imm);
         OP_ORI:   inst = i_word(OPC_ORI, rs, rt, imm);
         OP_LUI:   inst = i_word(OPC_LUI, REG_ZERO, rt, imm);
         OP_LW:    inst = i_word(OPC_LW, rs, rt, imm);
         OP_SW:    inst = i_word(OPC_SW, rs, rt, imm);
         OP_BEQ:   inst = i_word(OPC_BEQ, rs, rt, imm);
         OP_BNE:   inst = i_word(OPC_BNE, rs, rt, imm);
         OP_J:     inst = j_word(OPC_J, target);
         OP_JAL:   inst = j_word(OPC_JAL, target);
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder: streaming field-to-word MIPS-I encoder with a small output FIFO and pop counter
module mips_inst_encoder
   import mips_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_op,
   input  logic [4:0]       in_rs,
   input  logic [4:0]       in_rt,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_shamt,
   input  logic [15:0]      in_imm,
   input  logic [25:0]      in_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_illegal,
   output logic [CNT_W-1:0] inst_count
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   enc_inst;
   logic          enc_illegal;
   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          live;
   logic          push, pop;

   mips_field_encoder u_enc (
      .op      (in_op),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .shamt   (in_shamt),
      .imm     (in_imm),
      .target  (in_target),
      .inst    (enc_inst),
      .illegal (enc_illegal)
   );

   // live holds in_ready low until the first edge after reset release
   assign in_ready    = live && (count != (AW+1)'(DEPTH));
   assign out_valid   = count != '0;
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;
   assign out_inst    = out_valid ? mem[rd_ptr][31:0] : '0;
   assign out_illegal = out_valid && mem[rd_ptr][32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live       <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         inst_count <= '0;
      end else begin
         live       <= 1'b1;
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         count      <= count + (AW+1)'(push) - (AW+1)'(pop);
         inst_count <= inst_count + CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {enc_illegal, enc_inst};
   end

endmodule

// File: tb/tb_mips_inst_encoder.sv
// tb_mips_inst_encoder: directed vectors with hand-computed words for the streaming MIPS encoder
module tb_mips_inst_encoder;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_illegal;
   logic [3:0]  inst_count;
   int          checks = 0;
   int          passes = 0;

   localparam logic [31:0] W1 = 32'h35281234;
   localparam logic [31:0] W2 = 32'h3C09BEEF;
   localparam logic [31:0] W3 = 32'h08123456;

   mips_inst_encoder #(.DEPTH(2), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .in_shamt    (in_shamt),
      .in_imm      (in_imm),
      .in_target   (in_target),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_illegal (out_illegal),
      .inst_count  (inst_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) $display("FAIL %s got %h expected %h", tag, obs, exp);
      else passes++;
   endtask

   task automatic drive(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm, input logic [25:0] tgt);
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tgt;
      in_valid = 1'b1;
   endtask

   task automatic push(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm, input logic [25:0] tgt);
      int n = 0;
      drive(op, rs, rt, rd, sh, imm, tgt);
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 20) check("ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic push_chk(input string tag, input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                           input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] exp, input logic ill);
      push(op, rs, rt, rd, sh, imm, tgt);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check(tag, out_inst, exp);
      check({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
      step(); step();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_inst", out_inst, 32'd0);
      check("rst_ill", {31'd0, out_illegal}, 32'd0);
      check("rst_count", {28'd0, inst_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rdy_after_rst", {31'd0, in_ready}, 32'd1);

      push_chk("sll", OP_SLL, 5'd7, T0, T0, 5'd2, 16'hFFFF, 26'h3FFFFFF, 32'h00084080, 1'b0);
      push_chk("srl", OP_SRL, 5'd7, T0, T0, 5'd2, 16'h0000, 26'h0, 32'h00084082, 1'b0);
      push_chk("sra", OP_SRA, 5'd0, T1, T2, 5'd2, 16'h0000, 26'h0, 32'h00095083, 1'b0);
      step();
      check("cnt3", {28'd0, inst_count}, 32'd3);
      check("drained1", {31'd0, out_valid}, 32'd0);

      push_chk("addiu", OP_ADDIU, T1, T0, 5'd0, 5'd0, 16'd5, 26'h0, 32'h25280005, 1'b0);
      push_chk("addi", OP_ADDI, T5, T0, 5'd3, 5'd4, 16'd5, 26'h0, 32'h21A80005, 1'b0);
      push_chk("jalr", OP_JALR, T2, 5'd0, T1, 5'd0, 16'h0, 26'h0, 32'h01404809, 1'b0);
      push_chk("jr", OP_JR, RA, 5'd17, 5'd21, 5'd19, 16'hABCD, 26'h155, 32'h03E00008, 1'b0);
      step();
      check("cnt7", {28'd0, inst_count}, 32'd7);

      out_ready = 1'b0;
      drive(OP_ORI, T1, T0, 5'd0, 5'd0, 16'h1234, 26'h0);
      step();
      check("bp_rdy1", {31'd0, in_ready}, 32'd1);
      drive(OP_LUI, T2, T1, 5'd0, 5'd0, 16'hBEEF, 26'h0);
      step();
      check("bp_rdy2", {31'd0, in_ready}, 32'd0);
      check("bp_head", out_inst, W1);
      drive(OP_J, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h0123456);
      step();
      check("bp_hold", out_inst, W1);
      check("bp_rdy3", {31'd0, in_ready}, 32'd0);
      check("bp_cnt", {28'd0, inst_count}, 32'd7);
      out_ready = 1'b1;
      step();
      check("drain_w2", out_inst, W2);
      check("drain_rdy", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("drain_w3", out_inst, W3);
      step();
      check("drain_empty", {31'd0, out_valid}, 32'd0);
      check("cnt10", {28'd0, inst_count}, 32'd10);

      push_chk("illegal", 6'd40, 5'd3, 5'd4, 5'd5, 5'd6, 16'h7777, 26'h1, 32'h0, 1'b1);
      push_chk("nop", OP_NOP, 5'd3, 5'd4, 5'd5, 5'd6, 16'h7777, 26'h1, 32'h0, 1'b0);
      step();
      check("cnt12", {28'd0, inst_count}, 32'd12);

      out_ready = 1'b0;
      push(OP_ORI, T1, T0, 5'd0, 5'd0, 16'h1234, 26'h0);
      push(OP_LUI, T2, T1, 5'd0, 5'd0, 16'hBEEF, 26'h0);
      check("pre_rst_full", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", {31'd0, out_valid}, 32'd0);
      check("async_cnt", {28'd0, inst_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      push_chk("post_rst", OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0123456, W3, 1'b0);
      step();
      check("post_rst_alone", {31'd0, out_valid}, 32'd0);
      check("post_rst_cnt", {28'd0, inst_count}, 32'd1);

      do_reset();
      for (int i = 0; i < 17; i++) push(OP_ADDU, 5'(i), T0, T1, 5'd0, 16'h0, 26'h0);
      step();
      check("wrap_cnt", {28'd0, inst_count}, 32'd1);
      check("wrap_empty", {31'd0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mips_inst_encoder.md
Name: mips_inst_encoder

Overview:
Streaming MIPS-I instruction encoder, the inverse of the team's binary-to-MIPS decoder. It accepts decoded instruction fields (mnemonic enum plus register, shift, immediate and target fields) over a valid/ready handshake. It emits the packed 32-bit instruction word through a small output FIFO. It feeds instruction-memory preload logic and decoder round-trip checks.

Parameters:
DEPTH, 2, output FIFO entries; power of two, at least 2.
CNT_W, 16, width of the emitted-instruction counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_op  in  6  mnemonic enum, values from mips_pkg
in_rs  in  5  rs register number
in_rt  in  5  rt register number
in_rd  in  5  rd register number
in_shamt  in  5  shift amount
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target field
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts the word
out_inst  out  32  encoded instruction word
out_illegal  out  1  word came from an unsupported in_op
inst_count  out  CNT_W  words popped since reset

Behaviour:
- Reset (async, rst_n low): FIFO emptied, out_valid=0, out_inst=0, out_illegal=0, inst_count=0, in_ready=1 one cycle after release. Reset mid-stream discards all queued words. Nothing is replayed.
- Push: occurs when in_valid && in_ready at a rising edge. Encoding is combinational on the inputs and the result is stored with its illegal flag.
- in_ready = !full. It is registered-state only, with no combinational path from out_ready.
- Pop: occurs when out_valid && out_ready. out_inst/out_illegal show the FIFO head. They hold stable while out_valid && !out_ready.
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass.
- Simultaneous push and pop: both happen and occupancy is unchanged. At full, in_ready=0, so only the pop occurs. At empty, pop is impossible and a push makes occupancy 1.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a separate counter of 0..DEPTH.
- inst_count increments on each pop, including illegal words, and wraps modulo 2^CNT_W.
- Encoding forms:
  - R-type is {6'h00, rs, rt, rd, shamt, funct}.
  - I-type is {opcode, rs, rt, imm}.
  - J-type is {opcode, target}.
  - Fields unused by a form are forced to zero regardless of input.
- Functs: SLL 00, SRL 02, SRA 03, JR 08, JALR 09, ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, SLT 2A.
- Shift rules: SLL/SRL/SRA force rs=0. All other R-type forms force shamt=0.
- JR uses rs only. JALR uses rs and rd, with rd taken as given and no default to 31.
- Opcodes: ADDI 08, ADDIU 09, ANDI 0C, ORI 0D, LUI 0F, LW 23, SW 2B, BEQ 04, BNE 05, J 02, JAL 03. LUI forces rs=0.
- OP_NOP encodes 32'h00000000 with illegal=0.
- in_op values 24..63 encode 32'h00000000 with illegal=1. The word is still queued and counted.

Decomposition:
- mips_pkg holds:
  - Op enum: NOP=0, SLL=1, SRL=2, SRA=3, JR=4, JALR=5, ADD=6, ADDU=7, SUB=8, SUBU=9, AND=10, OR=11, SLT=12, ADDI=13, ADDIU=14, ANDI=15, ORI=16, LUI=17, LW=18, SW=19, BEQ=20, BNE=21, J=22, JAL=23.
  - Opcode and funct constants.
  - Register-name constants (T0=8, T1=9, T2=10, T5=13, RA=31).
  - This is shared with the decoder.
- One combinational sub-module, mips_field_encoder (fields in -> {inst, illegal} out), is instantiated once ahead of the FIFO. The FIFO stays inline.

Test Plan:
- Reset and R-type shifts, out_ready=1:
  - SLL rd=T0 rt=T0 shamt=2 -> 0x00084080.
  - SRL same fields -> 0x00084082.
  - SRA rd=T2 rt=T1 shamt=2 -> 0x00095083.
  - Each word appears one cycle after its push. inst_count ends at 3.
- Immediates and jumps:
  - ADDIU rt=T0 rs=T1 imm=5 -> 0x25280005.
  - ADDI rt=T0 rs=T5 imm=5 -> 0x21A80005.
  - JALR rd=T1 rs=T2 -> 0x01404809.
  - JR rs=RA, with garbage in_rd/in_shamt/in_imm -> 0x03E00008.
- Backpressure: hold out_ready=0 and stream 3 bundles with DEPTH=2.
  - in_ready drops after 2 pushes. out_inst holds the first word.
  - On release, the words drain in order and the third is then accepted.
- Illegal/NOP:
  - in_op=40 -> out_inst=0, out_illegal=1, counted.
  - OP_NOP -> 0, illegal=0.
- Reset mid-operation: with 2 words queued, pulse rst_n low asynchronously between edges.
  - out_valid drops immediately. inst_count=0.
  - The next push after release emerges alone.
- Counter wrap: CNT_W=4, pop 17 words -> inst_count=1.
